// File: rtl/sram_mem_requester_pkg.sv
// Shared constants for the MEM-stage SRAM requester and sram_controller_proc:
// FSM encoding, default address window and datapath widths.
package sram_mem_requester_pkg;

  localparam int WORD_W  = 32;
  localparam int SRAM_AW = 18;

  localparam logic [WORD_W-1:0] DEF_BASE_ADDR      = 32'd1024;
  localparam logic [WORD_W-1:0] DEF_MEM_BYTES      = 32'd2048;
  localparam int unsigned       DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

endpackage

// File: rtl/sram_req_addr_check.sv
// Combinational legality check for a MEM-stage request: one enable only,
// word aligned, and inside [BASE_ADDR, BASE_ADDR+MEM_BYTES) without wrap.
module sram_req_addr_check
  import sram_mem_requester_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [WORD_W-1:0] MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic              i_r_en,
  input  logic              i_w_en,
  input  logic [WORD_W-1:0] i_addr,
  output logic              o_req,
  output logic              o_legal
);

  // Upper bound is one bit wider so a window ending at 2^32 cannot wrap.
  localparam logic [WORD_W:0] LIMIT = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};

  logic w_single;
  logic w_aligned;
  logic w_in_window;

  assign w_single    = i_r_en ^ i_w_en;
  assign w_aligned   = (i_addr[1:0] == 2'b00);
  assign w_in_window = (i_addr >= BASE_ADDR) && ({1'b0, i_addr} < LIMIT);

  assign o_req   = i_r_en | i_w_en;
  assign o_legal = w_single & w_aligned & w_in_window;

endmodule

// File: rtl/sram_mem_requester.sv
// MEM-stage initiator for sram_controller_proc: hold-until-ready handshake,
// pipeline freeze and load capture. Optional watchdog: SRAM_REQ_TIMEOUT_EN.
module sram_mem_requester
  import sram_mem_requester_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR      = DEF_BASE_ADDR,
  parameter logic [WORD_W-1:0] MEM_BYTES      = DEF_MEM_BYTES,
  parameter int unsigned       TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic              freeze,
  output logic [WORD_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              err,
  output logic              ctl_wr_en,
  output logic              ctl_rd_en,
  output logic [WORD_W-1:0] ctl_addr,
  output logic [WORD_W-1:0] ctl_wdata,
  input  logic [WORD_W-1:0] ctl_rdata,
  input  logic              ctl_ready
);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_req;
  logic              w_legal;
  logic              w_issue;
  logic              w_reject;
  logic              w_done;
  logic              w_timeout;

  logic              r_ctl_wr_en;
  logic              r_ctl_rd_en;
  logic [WORD_W-1:0] r_ctl_addr;
  logic [WORD_W-1:0] r_ctl_wdata;
  logic [WORD_W-1:0] r_ld_data;
  logic              r_ld_valid;
  logic              r_err;

  sram_req_addr_check #(
    .BASE_ADDR (BASE_ADDR),
    .MEM_BYTES (MEM_BYTES)
  ) u_addr_check (
    .i_r_en  (mem_r_en),
    .i_w_en  (mem_w_en),
    .i_addr  (mem_addr),
    .o_req   (w_req),
    .o_legal (w_legal)
  );

`ifdef SRAM_REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_issue) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_BUSY) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th BUSY cycle; a late ready still wins.
  assign w_timeout = (r_state == ST_BUSY) && !ctl_ready &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; combinational logic below uses blocking (=).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    w_state_next = r_state;
    freeze       = 1'b0;
    w_issue      = 1'b0;
    w_reject     = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req && w_legal) begin
          freeze       = 1'b1;
          w_issue      = 1'b1;
          w_state_next = ST_BUSY;
        end else if (w_req) begin
          w_reject = 1'b1;
        end
      end
      ST_BUSY: begin
        freeze = 1'b1;
        if (ctl_ready) begin
          w_done       = 1'b1;
          w_state_next = ST_COMPLETE;
        end else if (w_timeout) begin
          w_state_next = ST_COMPLETE;
        end
      end
      // The pipeline latches here; mem_* still shows the served request.
      ST_COMPLETE: w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl_wr_en <= 1'b0;
      r_ctl_rd_en <= 1'b0;
      r_ctl_addr  <= '0;
      r_ctl_wdata <= '0;
      r_ld_data   <= '0;
      r_ld_valid  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ld_valid <= 1'b0;
      r_err      <= 1'b0;
      if (w_issue) begin
        r_ctl_wr_en <= mem_w_en;
        r_ctl_rd_en <= mem_r_en;
        r_ctl_addr  <= mem_addr;
        r_ctl_wdata <= mem_wdata;
      end
      if (w_reject) begin
        r_err <= 1'b1;
      end
      // Enables must be low the edge after ready or the controller restarts.
      if (w_done) begin
        r_ctl_wr_en <= 1'b0;
        r_ctl_rd_en <= 1'b0;
        if (r_ctl_rd_en) begin
          r_ld_data  <= ctl_rdata;
          r_ld_valid <= 1'b1;
        end
      end
      if (w_timeout) begin
        r_ctl_wr_en <= 1'b0;
        r_ctl_rd_en <= 1'b0;
        r_err       <= 1'b1;
      end
    end
  end

  assign ctl_wr_en = r_ctl_wr_en;
  assign ctl_rd_en = r_ctl_rd_en;
  assign ctl_addr  = r_ctl_addr;
  assign ctl_wdata = r_ctl_wdata;
  assign ld_data   = r_ld_data;
  assign ld_valid  = r_ld_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_sram_mem_requester.sv
// Scoreboard bench for sram_mem_requester with a 5-cycle behavioural SRAM
// controller; ld_valid/err pulses are matched against a queue of expectations.
module tb_sram_mem_requester;

  localparam int SVC_CYCLES = 5;

  typedef enum logic [1:0] { EV_LD = 2'd2, EV_ERR = 2'd1 } ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        freeze;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        err;
  logic        ctl_wr_en;
  logic        ctl_rd_en;
  logic [31:0] ctl_addr;
  logic [31:0] ctl_wdata;
  logic [31:0] ctl_rdata = '0;
  logic        ctl_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  ev_t exp_q[$];

  // Controller model state
  logic [31:0] sram [512];
  logic        do_preload = 1'b1;
  logic        ctl_stall  = 1'b0;
  int          svc_cnt    = 0;
  int          n_txn      = 0;
  int          n_en_cycles = 0;
  logic [31:0] w_off;
  assign w_off = ctl_addr - 32'h0000_0400;

  sram_mem_requester #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .freeze    (freeze),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .err       (err),
    .ctl_wr_en (ctl_wr_en),
    .ctl_rd_en (ctl_rd_en),
    .ctl_addr  (ctl_addr),
    .ctl_wdata (ctl_wdata),
    .ctl_rdata (ctl_rdata),
    .ctl_ready (ctl_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      ctl_ready <= 1'b0;
      svc_cnt   <= 0;
      if (do_preload) begin
        sram[0]   <= 32'hDEAD_BEEF;
        sram[2]   <= 32'hCAFE_F00D;
        sram[511] <= 32'hA5A5_5A5A;
      end
    end else if (ctl_ready) begin
      ctl_ready <= 1'b0;
      svc_cnt   <= 0;
    end else if ((ctl_rd_en || ctl_wr_en) && !ctl_stall) begin
      if (svc_cnt == SVC_CYCLES - 1) begin
        ctl_ready <= 1'b1;
        n_txn     <= n_txn + 1;
        if (ctl_wr_en) sram[w_off[10:2]] <= ctl_wdata;
        else           ctl_rdata <= sram[w_off[10:2]];
      end else begin
        svc_cnt <= svc_cnt + 1;
      end
    end else begin
      svc_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (ctl_rd_en || ctl_wr_en) n_en_cycles <= n_en_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // Monitor: every ld_valid/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (ld_valid || err)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pulse", {30'd0, ld_valid, err}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("sb_pulse_kind", {30'd0, ld_valid, err}, {30'd0, e.kind});
        if (e.kind == EV_LD) check("sb_ld_data", ld_data, e.data);
      end
    end
  end

  // Present one request, hold it while frozen, return at the release cycle.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int exp_frz, input string name);
    int nf = 0;
    @(posedge clk); #1;
    mem_r_en = r; mem_w_en = w; mem_addr = a; mem_wdata = d;
    forever begin
      @(negedge clk);
      if (!freeze) break;
      nf++;
      if (nf > 200) break;
    end
    check({name, "_freeze_cycles"}, nf, exp_frz);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  task automatic push_ld(input logic [31:0] d);
    ev_t e;
    e.kind = EV_LD; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.kind = EV_ERR; e.data = '0;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_freeze",    {31'd0, freeze},    32'd0);
    check("rst_ctl_rd_en", {31'd0, ctl_rd_en}, 32'd0);
    check("rst_ctl_wr_en", {31'd0, ctl_wr_en}, 32'd0);
    check("rst_ctl_addr",  ctl_addr,           32'd0);
    check("rst_ld_data",   ld_data,            32'd0);
    check("rst_ld_valid",  {31'd0, ld_valid},  32'd0);
    check("rst_err",       {31'd0, err},       32'd0);

    // Single load: frozen cycles 0-6, ld_valid in cycle 7.
    t0 = n_txn;
    push_ld(32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 32'h400, 32'h0, 7, "load_400");
    check("load_400_ld_valid_c7", {31'd0, ld_valid}, 32'd1);
    check("load_400_ld_data_c7",  ld_data, 32'hDEAD_BEEF);
    check("load_400_rd_en_low_c7", {31'd0, ctl_rd_en}, 32'd0);
    idle(2);
    check("load_400_txn_count", n_txn - t0, 32'd1);

    // Store then load back; the store produces no ld_valid.
    do_req(1'b0, 1'b1, 32'h404, 32'h1234_5678, 7, "store_404");
    check("store_404_no_ld_valid", {31'd0, ld_valid}, 32'd0);
    check("store_keeps_ld_data", ld_data, 32'hDEAD_BEEF);
    push_ld(32'h1234_5678);
    do_req(1'b1, 1'b0, 32'h404, 32'h0, 7, "load_404");
    idle(2);

    // Illegal requests: error pulse, no freeze, no controller activity.
    t0 = n_en_cycles;
    push_err();
    do_req(1'b1, 1'b0, 32'h402, 32'h0, 0, "misaligned_402");
    push_err();
    do_req(1'b1, 1'b0, 32'hC00, 32'h0, 0, "window_c00");
    push_err();
    do_req(1'b1, 1'b0, 32'h3FC, 32'h0, 0, "window_3fc");
    push_err();
    do_req(1'b1, 1'b1, 32'h400, 32'h0, 0, "both_en_400");
    idle(3);
    check("illegal_no_ctl_activity", n_en_cycles - t0, 32'd0);

    // Last word of the window is legal.
    push_ld(32'hA5A5_5A5A);
    do_req(1'b1, 1'b0, 32'hBFC, 32'h0, 7, "load_bfc");

    // Back-to-back loads held by the frozen pipeline.
    t0 = n_txn;
    push_ld(32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 32'h400, 32'h0, 7, "b2b_400");
    push_ld(32'hCAFE_F00D);
    do_req(1'b1, 1'b0, 32'h408, 32'h0, 7, "b2b_408");
    idle(3);
    check("b2b_txn_count", n_txn - t0, 32'd2);
    check("b2b_final_ld_data", ld_data, 32'hCAFE_F00D);

    // Reset during BUSY cycle 3.
    do_preload = 1'b0;
    @(posedge clk); #1;
    mem_r_en = 1'b1; mem_addr = 32'h400;
    repeat (3) @(posedge clk);
    #1;
    check("busy_c3_rd_en", {31'd0, ctl_rd_en}, 32'd1);
    rst = 1'b1; mem_r_en = 1'b0; mem_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rd_en",    {31'd0, ctl_rd_en}, 32'd0);
    check("midrst_freeze",   {31'd0, freeze},    32'd0);
    check("midrst_ld_valid", {31'd0, ld_valid},  32'd0);
    check("midrst_ld_data",  ld_data,            32'd0);
    push_ld(32'h1234_5678);
    do_req(1'b1, 1'b0, 32'h404, 32'h0, 7, "after_rst_404");
    idle(2);

`ifdef SRAM_REQ_TIMEOUT_EN
    ctl_stall = 1'b1;
    push_err();
    do_req(1'b1, 1'b0, 32'h400, 32'h0, 9, "timeout_400");
    check("timeout_rd_en_low", {31'd0, ctl_rd_en}, 32'd0);
    idle(2);
    ctl_stall = 1'b0;
    check("timeout_keeps_ld_data", ld_data, 32'h1234_5678);
`endif

    idle(4);
    check("sb_queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
